// File: rtl/vga_pkg.sv
// Shared timing defaults, sync bundle type and colour-bar helpers for the VGA scan path.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int PIX_LAT_DEF  = 0;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

  // Value the sync pipeline holds while nothing valid has been scanned yet.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Column to bar number, eight bars of 80 pixels each.
  function automatic logic [2:0] bar_index(input logic [9:0] x);
    if (x < 10'd80) begin
      return 3'd0;
    end else if (x < 10'd160) begin
      return 3'd1;
    end else if (x < 10'd240) begin
      return 3'd2;
    end else if (x < 10'd320) begin
      return 3'd3;
    end else if (x < 10'd400) begin
      return 3'd4;
    end else if (x < 10'd480) begin
      return 3'd5;
    end else if (x < 10'd560) begin
      return 3'd6;
    end else begin
      return 3'd7;
    end
  endfunction

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that resets to a programmable idle word; DEPTH=0 degenerates to a wire.
module vga_delay_line #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 0,
  parameter logic [WIDTH-1:0] IDLE  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_s;
      assign unused_s = clk ^ rst_n;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift stage by stage; reset refills every stage with the idle word.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_r[i] <= IDLE;
          end
        end else begin
          stage_r[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            stage_r[i] <= stage_r[i-1];
          end
        end
      end

      assign q = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// 640x480@60 raster timing generator with a registered, sync-aligned VGA DAC output stage.
// Build macro VGA_TEST_PATTERN_EN replaces i_rgb with eight vertical colour bars.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIX_LAT  = PIX_LAT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_active,
  input  logic [23:0] i_rgb,
  output logic [7:0]  o_vga_r,
  output logic [7:0]  o_vga_g,
  output logic [7:0]  o_vga_b,
  output logic        o_vga_hs,
  output logic        o_vga_vs,
  output logic        o_vga_blank_n,
  output logic        o_vga_sync_n,
  output logic        o_frame_start
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_STOP  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_STOP  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt_r;
  logic [9:0]  v_cnt_r;
  logic [9:0]  h_next_s;
  logic [9:0]  v_next_s;
  sync_t       sync_s;
  sync_t       sync_dly_s;
  logic [23:0] colour_s;
  logic [23:0] pix_rgb_s;
  logic [23:0] rgb_r;
  logic        hs_r;
  logic        vs_r;
  logic        blank_n_r;
  logic        frame_start_r;

  // Next raster position: h wraps every line, v steps only on that wrap.
  always_comb begin
    h_next_s = h_cnt_r + 10'd1;
    v_next_s = v_cnt_r;
    if (h_cnt_r == H_LAST) begin
      h_next_s = 10'd0;
      if (v_cnt_r == V_LAST) begin
        v_next_s = 10'd0;
      end else begin
        v_next_s = v_cnt_r + 10'd1;
      end
    end else begin
      h_next_s = h_cnt_r + 10'd1;
      v_next_s = v_cnt_r;
    end
  end

  // Raster position registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else begin
      h_cnt_r <= h_next_s;
      v_cnt_r <= v_next_s;
    end
  end

  // Region decode of the current position (sync pulses are active-low).
  always_comb begin
    sync_s.active = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
    sync_s.hs     = ~((h_cnt_r >= HS_START) && (h_cnt_r < HS_STOP));
    sync_s.vs     = ~((v_cnt_r >= VS_START) && (v_cnt_r < VS_STOP));
  end

  assign o_active = sync_s.active;
  assign o_x      = sync_s.active ? h_cnt_r : 10'd0;
  assign o_y      = sync_s.active ? v_cnt_r[8:0] : 9'd0;

  // Timing flags travel alongside the ROM latency so they meet their colour at the pins.
  vga_delay_line #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (PIX_LAT),
    .IDLE  (SYNC_IDLE)
  ) u_sync_dly (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (sync_s),
    .q     (sync_dly_s)
  );

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0]  bar_s;
  logic [2:0]  bar_dly_s;
  logic [23:0] unused_rgb_s;

  assign bar_s        = bar_index(h_cnt_r);
  assign unused_rgb_s = i_rgb;

  vga_delay_line #(
    .WIDTH (3),
    .DEPTH (PIX_LAT),
    .IDLE  (3'd0)
  ) u_bar_dly (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (bar_s),
    .q     (bar_dly_s)
  );

  assign colour_s = bar_colour(bar_dly_s);
`else
  assign colour_s = i_rgb;
`endif

  // Blanking overrides whatever colour the source presents.
  always_comb begin
    pix_rgb_s = 24'd0;
    if (sync_dly_s.active) begin
      pix_rgb_s = colour_s;
    end else begin
      pix_rgb_s = 24'd0;
    end
  end

  // Output register stage feeding the DAC pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rgb_r         <= 24'd0;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      blank_n_r     <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      rgb_r         <= pix_rgb_s;
      hs_r          <= sync_dly_s.hs;
      vs_r          <= sync_dly_s.vs;
      blank_n_r     <= sync_dly_s.active;
      frame_start_r <= (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
    end
  end

  assign o_vga_r       = rgb_r[23:16];
  assign o_vga_g       = rgb_r[15:8];
  assign o_vga_b       = rgb_r[7:0];
  assign o_vga_hs      = hs_r;
  assign o_vga_vs      = vs_r;
  assign o_vga_blank_n = blank_n_r;
  assign o_vga_sync_n  = 1'b0;
  assign o_frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl: a PIX_LAT=0 instance with a combinational pattern source and a
// PIX_LAT=2 instance behind a two-stage registered stub ROM. Vertical timing is shortened to keep runs brief.
module tb_vga_scan_ctrl;

  localparam int HT    = 800;
  localparam int VA    = 40;
  localparam int VF    = 2;
  localparam int VS    = 2;
  localparam int VB    = 4;
  localparam int VT    = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int WHITE_FROM = 30 * HT;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [23:0] EXP_X17 = 24'hFFFFFF;
  localparam logic [23:0] EXP_X85 = 24'hFFFF00;
  localparam logic [23:0] EXP_X639 = 24'h000000;
  localparam logic [23:0] EXP_ORIGIN = 24'hFFFFFF;
  localparam logic [23:0] EXP_WHITE639 = 24'h000000;
`else
  localparam logic [23:0] EXP_X17 = 24'h1103A5;
  localparam logic [23:0] EXP_X85 = 24'h5500A5;
  localparam logic [23:0] EXP_X639 = 24'h7F00A5;
  localparam logic [23:0] EXP_ORIGIN = 24'h0000A5;
  localparam logic [23:0] EXP_WHITE639 = 24'hFFFFFF;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_white = 1'b0;
  always #20 clk = ~clk;

  logic [9:0]  x0, x2;
  logic [8:0]  y0, y2;
  logic        act0, act2;
  logic [23:0] rgb0_in, rgb2_in;
  logic [7:0]  r0, g0, b0, r2, g2, b2;
  logic        hs0, vs0, bn0, sn0, fs0;
  logic        hs2, vs2, bn2, sn2, fs2;
  logic [23:0] rom_s1, rom_s2;

  int n_checks = 0;
  int n_fails  = 0;

  assign rgb0_in = force_white ? 24'hFFFFFF : {x0[7:0], y0[7:0], 8'hA5};

  always @(posedge clk) begin
    rom_s1 <= force_white ? 24'hFFFFFF : {x2[7:0], y2[7:0], 8'hA5};
    rom_s2 <= rom_s1;
  end
  assign rgb2_in = rom_s2;

  vga_scan_ctrl #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIX_LAT(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(x0), .o_y(y0), .o_active(act0), .i_rgb(rgb0_in),
    .o_vga_r(r0), .o_vga_g(g0), .o_vga_b(b0), .o_vga_hs(hs0), .o_vga_vs(vs0),
    .o_vga_blank_n(bn0), .o_vga_sync_n(sn0), .o_frame_start(fs0)
  );

  vga_scan_ctrl #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .PIX_LAT(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .o_x(x2), .o_y(y2), .o_active(act2), .i_rgb(rgb2_in),
    .o_vga_r(r2), .o_vga_g(g2), .o_vga_b(b2), .o_vga_hs(hs2), .o_vga_vs(vs2),
    .o_vga_blank_n(bn2), .o_vga_sync_n(sn2), .o_frame_start(fs2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_colour(input int h);
    case (h / 80)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic is_white(input int j);
    return (j >= WHITE_FROM) && (j < FRAME);
  endfunction

  // Expected pins {rgb, hs, vs, blank_n} for raster index j.
  function automatic logic [26:0] exp_pins(input int j, input logic white);
    int h, v;
    logic act;
    logic [23:0] c;
    h = j % HT;
    v = (j / HT) % VT;
    act = (h < 640) && (v < VA);
`ifdef VGA_TEST_PATTERN_EN
    c = bar_colour(h);
`else
    c = white ? 24'hFFFFFF : {h[7:0], v[7:0], 8'hA5};
`endif
    if (!act) c = 24'd0;
    return {c, !((h >= 656) && (h < 752)), !((v >= VA + VF) && (v < VA + VF + VS)), act};
  endfunction

  // Expected {o_x, o_y, o_active} while the counters sit at index j.
  function automatic logic [19:0] exp_xy(input int j);
    int h, v;
    logic act;
    h = j % HT;
    v = (j / HT) % VT;
    act = (h < 640) && (v < VA);
    return act ? {h[9:0], v[8:0], 1'b1} : 20'd0;
  endfunction

  initial begin
    int fs_cnt, fs_first, hs_low, vs_low, bn_high, mm0, mm2, mmxy, leak;
    logic [26:0] p0, p2;
    fs_cnt = 0; fs_first = 0; hs_low = 0; vs_low = 0; bn_high = 0;
    mm0 = 0; mm2 = 0; mmxy = 0; leak = 0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rgb", {r0, g0, b0}, 24'd0);
    check_eq("rst_hs", hs0, 1'b1);
    check_eq("rst_vs", vs0, 1'b1);
    check_eq("rst_blank_n", bn0, 1'b0);
    check_eq("rst_sync_n", sn0, 1'b0);
    check_eq("rst_frame_start", fs0, 1'b0);
    check_eq("rst_xy", {x0, y0}, 19'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 1; k <= FRAME; k++) begin
      force_white = is_white(k - 1);
      @(posedge clk);
      #1;
      p0 = {r0, g0, b0, hs0, vs0, bn0};
      p2 = {r2, g2, b2, hs2, vs2, bn2};
      if (p0 !== exp_pins(k - 1, is_white(k - 1))) mm0++;
      if (k >= 3) begin
        if (p2 !== exp_pins(k - 3, is_white(k - 3))) mm2++;
      end else begin
        if (p2 !== {24'd0, 1'b1, 1'b1, 1'b0}) mm2++;
      end
      if ({x0, y0, act0} !== exp_xy(k)) mmxy++;
      if (fs0) begin
        fs_cnt++;
        if (fs_first == 0) fs_first = k;
      end
      if (!hs0) hs_low++;
      if (!vs0) vs_low++;
      if (bn0) bn_high++;
      if (!bn0 && ({r0, g0, b0} != 24'd0)) leak++;

      if (k == 86)    check_eq("pix_x85", {r0, g0, b0}, EXP_X85);
      if (k == 640)   check_eq("pix_x639", {r0, g0, b0}, EXP_X639);
      if (k == 641)   check_eq("hfp_blank_n", bn0, 1'b0);
      if (k == 657)   check_eq("hs_fall_lat0", hs0, 1'b0);
      if (k == 658)   check_eq("hs_before_fall_lat2", hs2, 1'b1);
      if (k == 659)   check_eq("hs_fall_lat2", hs2, 1'b0);
      if (k == 2418) begin
        check_eq("pix_17_3_rgb", {r0, g0, b0}, EXP_X17);
        check_eq("pix_17_3_blank_n", bn0, 1'b1);
      end
      if (k == 2419)  check_eq("lat2_not_yet", {r2, g2, b2}, (EXP_X17 == 24'hFFFFFF) ? 24'hFFFFFF : 24'h1003A5);
      if (k == 2420)  check_eq("lat2_pix_17_3", {r2, g2, b2, bn2}, {EXP_X17, 1'b1});
      if (k == 28640) check_eq("white_x639", {r0, g0, b0}, EXP_WHITE639);
      if (k == 28641) check_eq("white_hblank", {r0, g0, b0, bn0}, 25'd0);
      if (k == 33601) check_eq("vs_fall", vs0, 1'b0);
      if (k == 35301) check_eq("white_vblank", {r0, g0, b0, bn0}, 25'd0);
    end
    force_white = 1'b0;

    check_eq("frame_start_count", fs_cnt, 32'd1);
    check_eq("frame_start_first", fs_first, 32'd1);
    check_eq("hs_low_cycles", hs_low, 32'(96 * VT));
    check_eq("vs_low_cycles", vs_low, 32'(VS * HT));
    check_eq("blank_n_high_cycles", bn_high, 32'(640 * VA));
    check_eq("lat0_pin_mismatches", mm0, 32'd0);
    check_eq("lat2_pin_mismatches", mm2, 32'd0);
    check_eq("xy_mismatches", mmxy, 32'd0);
    check_eq("rgb_during_blank", leak, 32'd0);

    // Walk into the next frame up to (300,20), then reset mid-line.
    repeat (20 * HT + 300) @(posedge clk);
    #1;
    check_eq("pre_reset_xy", {x0, y0}, {10'd300, 9'd20});
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rgb", {r0, g0, b0}, 24'd0);
    check_eq("mid_rst_sync", {hs0, vs0, bn0, fs0}, 4'b1100);
    check_eq("mid_rst_lat2", {r2, g2, b2, hs2, vs2, bn2}, {24'd0, 3'b110});
    check_eq("mid_rst_xy", {x0, y0}, 19'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("restart_frame_start", {fs0, fs2}, 2'b11);
    check_eq("restart_pix00", {r0, g0, b0, bn0}, {EXP_ORIGIN, 1'b1});
    check_eq("restart_xy", {x0, y0}, {10'd1, 9'd0});
    check_eq("restart_lat2_idle", bn2, 1'b0);
    @(posedge clk);
    #1;
    check_eq("frame_start_one_cycle", fs0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("restart_lat2_pix00", {r2, g2, b2, bn2}, {EXP_ORIGIN, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
